regfile_dump_unit: RTL and testbench
====================================

Name: regfile_dump_unit

Overview:
- Hardware counterpart of the bench-side state checks: counts clock cycles after reset and, at a programmed stop cycle or on request, freezes the pipeline.
- It then streams a snapshot of PC, EXEC-stage ALU result and a window of register-file entries over a valid/ready interface.
- Sits beside Top and reads the register file through a dedicated read port, so a host, UART bridge or bench consumer can collect architectural state without hierarchical references.

Parameters:
- FIRST_REG, 16, index of the first register streamed (0..31)
- LAST_REG, 23, index of the last register streamed (FIRST_REG..31; LAST_REG < FIRST_REG is illegal)
- CNT_W, 32, width of cycle counter and stop_cycle

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- stop_cycle  in  CNT_W  cycle number at which to freeze; 0 = disabled
- force_dump  in  1  request immediate freeze+dump (level, sampled in RUN only)
- pc_in  in  32  current program counter
- alu_out_in  in  32  EXEC-stage ALU result
- rf_addr  out  5  register-file debug read address
- rf_data  in  32  register-file debug read data (combinational from rf_addr)
- freeze  out  1  stalls pipeline and blocks all register-file writes while high
- dump_valid  out  1  beat valid
- dump_ready  in  1  consumer accepts beat
- dump_tag  out  6  0..31 = register index, 32 = PC, 33 = ALUOut
- dump_data  out  32  beat payload
- done  out  1  snapshot fully transferred
- cycle_count  out  CNT_W  current cycle number

Behaviour:
- Reset (synchronous, any state):
  - state=RUN, cycle_count=1.
  - freeze=0, dump_valid=0, done=0, dump_tag=0, dump_data=0, rf_addr=0.
  - Captured PC/ALU registers cleared.
- States: RUN, STREAM, DONE.
- RUN:
  - cycle_count increments by 1 every clk edge; wraps 2^CNT_W-1 -> 0.
  - Trigger condition: (stop_cycle != 0 and cycle_count == stop_cycle) or force_dump.
  - On the edge where the trigger is true: latch pc_in and alu_out_in, freeze<=1, state<=STREAM, beat index<=PC.
  - cycle_count holds the trigger value (does not increment on that edge).
  - Simultaneous match and force_dump produce exactly one dump.
- STREAM, beat order: PC (tag 32), ALUOut (tag 33), then registers FIRST_REG..LAST_REG ascending (tag = index).
  - dump_valid=1 from the first cycle after the trigger.
  - Beat transfers on an edge with dump_valid && dump_ready.
  - While dump_valid && !dump_ready: dump_tag and dump_data hold stable.
  - rf_addr = current register index during register beats and FIRST_REG otherwise.
  - dump_data for register beats = rf_data combinationally; it is stable because freeze blocks writes.
  - dump_ready held high gives one beat per cycle. Total beats = LAST_REG-FIRST_REG+3.
  - force_dump and stop_cycle are ignored in STREAM and DONE; cycle_count frozen.
- After the last beat transfers: dump_valid<=0, done<=1, state<=DONE.
- DONE: freeze=1 and done=1 held until reset.
- Reset mid-STREAM: the partial stream is aborted and no further beats are emitted; the consumer must discard the incomplete snapshot.

Optional Feature:
- Macro DUMP_RESUME_EN.
- When defined:
  - Adds input resume (1 bit).
  - In DONE, resume=1 on an edge gives freeze<=0, done<=0, state<=RUN.
  - cycle_count continues from the held value +1 on that edge.
  - A later stop_cycle match or force_dump re-triggers a dump.
- When undefined: no resume port; DONE is exit-only via reset.

Test Plan:
- FIRST_REG=19, LAST_REG=23; preload regs 19..23 = 15,10,3,25,28; pc_in=640, alu_out_in=28; stop_cycle=11; dump_ready=1 -> freeze rises after edge at cycle 11, cycle_count stays 11. Beats (32,640),(33,28),(19,15),(20,10),(21,3),(22,25),(23,28) on 7 consecutive cycles, then done=1.
- Same setup, dump_ready toggling 1,0,0,1 -> no beat lost or duplicated; tag/data stable during stalls; done after 7 accepted beats.
- stop_cycle=0, force_dump pulsed at cycle 5 -> freeze set, cycle_count=5, full 7-beat stream. force_dump at cycle 5 with stop_cycle=5 -> single stream only.
- reset asserted after beat 3 of a stream -> next cycle freeze=0, dump_valid=0, done=0, cycle_count=1. Re-trigger at stop_cycle=4 gives a fresh complete stream starting with tag 32.
- Pipeline attempts RF write during STREAM -> freeze blocks it; streamed value equals pre-freeze value.
- DUMP_RESUME_EN defined: resume in DONE at cycle_count=11 -> RUN, count 12 next edge; stop_cycle reprogrammed to 20 -> second dump at count 20.

Source files
------------

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: freezes the pipeline at a stop cycle or on request and streams PC, ALUOut and a register window; DUMP_RESUME_EN adds a resume input
module regfile_dump_unit #(
  parameter int FIRST_REG = 16,
  parameter int LAST_REG  = 23,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] stop_cycle,
  input  logic             force_dump,
`ifdef DUMP_RESUME_EN
  input  logic             resume,
`endif
  input  logic [31:0]      pc_in,
  input  logic [31:0]      alu_out_in,
  output logic [4:0]       rf_addr,
  input  logic [31:0]      rf_data,
  output logic             freeze,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [5:0]       dump_tag,
  output logic [31:0]      dump_data,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);
  typedef enum logic [1:0] {RUN, STREAM, DONE} state_t;
  localparam logic [5:0] TAG_PC  = 6'd32;
  localparam logic [5:0] TAG_ALU = 6'd33;
  localparam logic [5:0] FIRST   = 6'(FIRST_REG);
  localparam logic [5:0] LAST    = 6'(LAST_REG);
  state_t state, state_nxt;
  logic [5:0] beat, beat_nxt;
  logic [31:0] pc_q, alu_q;
  logic trig, xfer, resume_go;
  assign trig = ((stop_cycle != '0) && (cycle_count == stop_cycle)) || force_dump;
  assign xfer = dump_valid && dump_ready;
`ifdef DUMP_RESUME_EN
  assign resume_go = resume;
`else
  assign resume_go = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    if (state == RUN && trig) begin
      state_nxt = STREAM;
      beat_nxt  = TAG_PC;
    end else if (state == STREAM && xfer) begin
      state_nxt = (beat == LAST) ? DONE : STREAM;
      beat_nxt  = (beat == TAG_PC) ? TAG_ALU : (beat == TAG_ALU) ? FIRST : beat + 6'd1;
    end else if (state == DONE && resume_go) begin
      state_nxt = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      beat        <= '0;
      cycle_count <= CNT_W'(1);
      pc_q        <= '0;
      alu_q       <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if ((state == RUN && !trig) || (state == DONE && resume_go))
        cycle_count <= cycle_count + CNT_W'(1);
      if (state == RUN && trig) begin
        pc_q  <= pc_in;
        alu_q <= alu_out_in;
      end
    end
  end
  assign freeze     = state != RUN;
  assign dump_valid = state == STREAM;
  assign done       = state == DONE;
  assign dump_tag   = dump_valid ? beat : 6'd0;
  assign rf_addr    = !dump_valid ? 5'd0 : beat[5] ? FIRST[4:0] : beat[4:0];
  assign dump_data  = !dump_valid ? 32'd0 : (beat == TAG_PC) ? pc_q : (beat == TAG_ALU) ? alu_q : rf_data;
endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: random and directed snapshot streams checked against a queue-based reference
module tb_regfile_dump_unit;
  localparam int FIRST = 19;
  localparam int LAST  = 23;
  typedef struct { logic [5:0] tag; logic [31:0] data; } beat_t;
  logic clk = 0, reset = 1, force_dump = 0, dump_ready = 0, freeze, dump_valid, done;
  logic resume = 0;
  logic [31:0] stop_cycle = 0, pc_in = 0, alu_out_in = 0, rf_data, dump_data, cycle_count;
  logic [4:0] rf_addr;
  logic [5:0] dump_tag;
  logic [31:0] rf [32];
  logic [31:0] load_vals [32];
  logic load = 0, we = 0, rand_io = 0;
  logic [4:0] wa = 0;
  logic [31:0] wd = 0, exp_pc, exp_alu;
  int checks = 0, failures = 0, trig_k = 0;
  beat_t exp_q [$];

  regfile_dump_unit #(.FIRST_REG(FIRST), .LAST_REG(LAST), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stop_cycle(stop_cycle), .force_dump(force_dump),
`ifdef DUMP_RESUME_EN
    .resume(resume),
`endif
    .pc_in(pc_in), .alu_out_in(alu_out_in), .rf_addr(rf_addr), .rf_data(rf_data),
    .freeze(freeze), .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_tag(dump_tag),
    .dump_data(dump_data), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (load) rf <= load_vals;
    else if (we && !freeze) rf[wa] <= wd;
  assign rf_data = rf[rf_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input bit directed);
    reset = 1; load = 1; force_dump = 0; dump_ready = 0; we = 0; resume = 0;
    for (int i = 0; i < 32; i++) load_vals[i] = $urandom;
    if (directed) begin
      load_vals[19] = 15; load_vals[20] = 10; load_vals[21] = 3; load_vals[22] = 25; load_vals[23] = 28;
    end
    @(posedge clk); @(negedge clk);
    load = 0;
    chk("rst_freeze", freeze, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_count", cycle_count, 1);
    chk("rst_tag", dump_tag, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_rf_addr", rf_addr, 0);
    reset = 0;
  endtask

  task automatic run_phase(input int k0, input int stop, input int fat, input bit wr);
    int k = k0;
    bit hit = 0;
    stop_cycle = stop;
    for (int n = 0; n < 200 && !hit; n++) begin
      chk("run_count", cycle_count, k);
      chk("run_freeze", freeze, 0);
      chk("run_valid", dump_valid, 0);
      pc_in = rand_io ? $urandom : 640;
      alu_out_in = rand_io ? $urandom : 28;
      force_dump = (k == fat);
      we = wr && ($urandom_range(0, 1) == 1);
      wa = 5'($urandom_range(FIRST, LAST));
      wd = $urandom;
      hit = (stop != 0 && k == stop) || k == fat;
      if (hit) begin
        exp_pc = pc_in; exp_alu = alu_out_in; trig_k = k;
      end
      @(posedge clk); @(negedge clk);
      if (!hit) k++;
    end
    force_dump = 0; we = 0;
    chk("run_trigger_seen", hit, 1);
    chk("trig_freeze", freeze, 1);
    chk("trig_count_held", cycle_count, trig_k);
    exp_q.delete();
    exp_q.push_back('{6'd32, exp_pc});
    exp_q.push_back('{6'd33, exp_alu});
    for (int r = FIRST; r <= LAST; r++) exp_q.push_back('{6'(r), rf[r]});
  endtask

  task automatic stream_phase(input int mode, input int abort_after);
    logic [3:0] pat = 4'b1001;
    logic [5:0] lt = 0;
    logic [31:0] ld = 0;
    bit stalled = 0;
    int got = 0, n = 0;
    beat_t e;
    while (exp_q.size() > 0 && n < 100 && !(abort_after != 0 && got >= abort_after)) begin
      dump_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[n % 4] : 1'($urandom_range(0, 1));
      force_dump = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(FIRST, LAST));
      wd = $urandom;
      pc_in = $urandom; alu_out_in = $urandom;
      chk("str_valid", dump_valid, 1);
      chk("str_freeze", freeze, 1);
      chk("str_done", done, 0);
      chk("str_count", cycle_count, trig_k);
      chk("str_rf_addr", rf_addr, exp_q[0].tag[5] ? 5'(FIRST) : exp_q[0].tag[4:0]);
      if (stalled) begin
        chk("stall_tag", dump_tag, lt);
        chk("stall_data", dump_data, ld);
      end
      lt = dump_tag; ld = dump_data;
      if (dump_valid && dump_ready) begin
        e = exp_q.pop_front();
        chk("beat_tag", dump_tag, e.tag);
        chk("beat_data", dump_data, e.data);
        got++;
        stalled = 0;
      end else stalled = 1;
      n++;
      @(posedge clk); @(negedge clk);
    end
    we = 0;
    if (abort_after != 0) return;
    chk("stream_complete", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      chk("done_valid", dump_valid, 0);
      chk("done_done", done, 1);
      chk("done_freeze", freeze, 1);
      chk("done_count", cycle_count, trig_k);
      force_dump = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
    end
    force_dump = 0;
  endtask

  initial begin
    int stop, fat;
    @(negedge clk);
    do_reset(1); rand_io = 0;
    run_phase(1, 11, 0, 0); stream_phase(0, 0);
`ifdef DUMP_RESUME_EN
    resume = 1;
    @(posedge clk); @(negedge clk);
    resume = 0;
    chk("resume_freeze", freeze, 0);
    chk("resume_done", done, 0);
    chk("resume_count", cycle_count, 12);
    run_phase(12, 20, 0, 0); stream_phase(0, 0);
`endif
    do_reset(1); run_phase(1, 11, 0, 0); stream_phase(1, 0);
    do_reset(1); run_phase(1, 0, 5, 0); stream_phase(0, 0);
    do_reset(1); run_phase(1, 5, 5, 0); stream_phase(0, 0);
    do_reset(1); run_phase(1, 11, 0, 0); stream_phase(0, 3);
    do_reset(1); run_phase(1, 4, 0, 0); stream_phase(0, 0);
    rand_io = 1;
    for (int t = 0; t < 8; t++) begin
      do_reset(0);
      stop = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : 0;
      fat = (stop == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
      run_phase(1, stop, fat, 1);
      stream_phase($urandom_range(0, 2), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
